// File: rtl/cordic_rr_scheduler_if.sv
// Request, response and CORDIC-pipeline signals of cordic_rr_scheduler.
// The master view belongs to the scheduler; the slave view is the requesters plus the datapath.
interface cordic_rr_scheduler_if #(
  parameter int N_REQ     = 4,
  parameter int BIT_WIDTH = 16
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*BIT_WIDTH-1:0] req_angle;
  logic [N_REQ-1:0]           resp_valid;
  logic [N_REQ-1:0]           resp_ready;
  logic signed [BIT_WIDTH-1:0] resp_x;
  logic signed [BIT_WIDTH-1:0] resp_y;
  logic                        pipe_start;
  logic                        pipe_valid;
  logic signed [BIT_WIDTH-1:0] pipe_angle;
  logic                        pipe_out_done;
  logic signed [BIT_WIDTH-1:0] pipe_out_x;
  logic signed [BIT_WIDTH-1:0] pipe_out_y;

  modport master (
    input  req_valid, req_angle, resp_ready, pipe_out_done, pipe_out_x, pipe_out_y,
    output req_ready, resp_valid, resp_x, resp_y, pipe_start, pipe_valid, pipe_angle
  );

  modport slave (
    output req_valid, req_angle, resp_ready, pipe_out_done, pipe_out_x, pipe_out_y,
    input  req_ready, resp_valid, resp_x, resp_y, pipe_start, pipe_valid, pipe_angle
  );
endinterface

// File: rtl/cordic_rr_scheduler.sv
// Shares one STAGES-deep CORDIC pipeline among N_REQ requesters with a tag shift register.
// Define CORDIC_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module cordic_rr_scheduler #(
  parameter int N_REQ     = 4,
  parameter int BIT_WIDTH = 16,
  parameter int STAGES    = 16,
  localparam int TAG_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input logic clk,
  input logic reset,
  cordic_rr_scheduler_if.master bus
);

  logic                        resp_fire;
  logic                        pipe_start;
  logic                        accept;
  logic                        grant_found;
  logic [TAG_W-1:0]            grant_idx;
  logic [N_REQ-1:0]            grant_vec;
  logic                        capture;
  logic [STAGES-1:0]           vld_p;
  logic [TAG_W-1:0]            tag_p [STAGES];
  logic                        out_full;
  logic [TAG_W-1:0]            out_tag;
  logic signed [BIT_WIDTH-1:0] out_x;
  logic signed [BIT_WIDTH-1:0] out_y;

  // A full holding register only lets the pipeline advance when it drains this cycle.
  assign resp_fire  = |(bus.resp_valid & bus.resp_ready);
  assign pipe_start = ~out_full | resp_fire;

`ifndef CORDIC_SCHED_FIXED_PRIO_EN
  logic [TAG_W-1:0] rr_ptr;
`endif

  always_comb begin
    int               j;
    logic [TAG_W-1:0] cand;
    j           = 0;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
      j = k;
`else
      j = int'(rr_ptr) + 1 + k;
      if (j >= N_REQ) j = j - N_REQ;
`endif
      cand = TAG_W'(j);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept         = grant_found & pipe_start;
  assign grant_vec      = accept ? (N_REQ'(1) << grant_idx) : '0;
  assign bus.req_ready  = grant_vec;
  assign bus.pipe_valid = accept;
  assign bus.pipe_angle = grant_found ? bus.req_angle[grant_idx*BIT_WIDTH +: BIT_WIDTH] : '0;

`ifndef CORDIC_SCHED_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= TAG_W'(N_REQ - 1);
    else if (accept) rr_ptr <= grant_idx;
  end
`endif

  // Stage p0..p(STAGES-1): owner tags ride alongside the datapath, frozen during a stall.
  always_ff @(posedge clk) begin
    if (reset)           vld_p <= '0;
    else if (pipe_start) vld_p <= {vld_p[STAGES-2:0], accept};
  end

  always_ff @(posedge clk) begin
    if (pipe_start) begin
      tag_p[0] <= grant_idx;
      for (int i = 1; i < STAGES; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Output stage: a capture that coincides with a fire simply overwrites the drained entry.
  assign capture = pipe_start & vld_p[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_full <= 1'b0;
      out_tag  <= '0;
      out_x    <= '0;
      out_y    <= '0;
    end else if (capture) begin
      out_full <= 1'b1;
      out_tag  <= tag_p[STAGES-1];
      out_x    <= bus.pipe_out_x;
      out_y    <= bus.pipe_out_y;
    end else if (resp_fire) begin
      out_full <= 1'b0;
    end
  end

  assign bus.resp_valid = out_full ? (N_REQ'(1) << out_tag) : '0;
  assign bus.resp_x     = out_x;
  assign bus.resp_y     = out_y;
  assign bus.pipe_start = pipe_start;

endmodule
